axi_tensor_wr_burst: RTL and testbench

Parametrised AXI4 write-back engine. Streams the PE array's accumulator register files to DRAM starting at a programmable base address. Splits the transfer into INCR bursts of at most MAX_BURST beats that never cross a 4 KB boundary, and waits for each B response. Sits between the PE array and the AXI interconnect, and replaces the fixed single-burst writer.

---
 rtl/axi_tensor_wr_burst_pkg.sv | 20 ++
 rtl/axi_tensor_wr_burst_planner.sv | 31 +++
 rtl/axi_tensor_wr_burst.sv | 182 ++++++++++++++++++
 tb/tb_axi_tensor_wr_burst.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tensor_wr_burst_pkg.sv
// Shared types and AXI constants for the tensor write-back engine.
package axi_tensor_wr_burst_pkg;

    typedef enum logic {
        WR_NORMAL,
        WR_PACK_FP16
    } wr_mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_4KB        = 4096;

endpackage

// File: rtl/axi_tensor_wr_burst_planner.sv
// Burst sizing: clamps a burst to MAX_BURST, the remaining beats
// and the distance to the next 4 KB page.
module wr_burst_planner
    import axi_tensor_wr_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_W      = 9,
    parameter int SIZE       = 2,
    parameter int MAX_BURST  = 256
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [CNT_W-1:0]      beats_left,
    output logic [8:0]            len,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [31:0] room;
    logic [31:0] left;
    logic [31:0] m;

    always_comb begin
        room = (32'(AXI_4KB) - 32'(addr[11:0])) >> SIZE;
        left = 32'(beats_left);
        m    = 32'(MAX_BURST);
        if (left < m) m = left;
        if (room < m) m = room;
        len       = m[8:0];
        next_addr = addr + ADDR_WIDTH'(m << SIZE);
    end

endmodule

// File: rtl/axi_tensor_wr_burst.sv
// AXI4 write-back of the PE accumulator register files, split into
// INCR bursts that never cross a 4 KB page, one burst outstanding.
module axi_tensor_wr_burst
    import axi_tensor_wr_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int RF_WIDTH   = 128,
    parameter int MAX_BURST  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pack_fp16,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ROWS*COLS*RF_WIDTH-1:0] regfiles,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic                         axi_awvalid,
    input  logic                         axi_awready,
    output logic [ADDR_WIDTH-1:0]        axi_awaddr,
    output logic [7:0]                   axi_awlen,
    output logic [2:0]                   axi_awsize,
    output logic [1:0]                   axi_awburst,
    output logic                         axi_wvalid,
    input  logic                         axi_wready,
    output logic [DATA_WIDTH-1:0]        axi_wdata,
    output logic [DATA_WIDTH/8-1:0]      axi_wstrb,
    output logic                         axi_wlast,
    input  logic                         axi_bvalid,
    output logic                         axi_bready,
    input  logic [1:0]                   axi_bresp
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int SIZE    = $clog2(BYTES);
    localparam int NPE     = ROWS * COLS;
    localparam int TOTAL_N = NPE * RF_WIDTH / DATA_WIDTH;
    localparam int TOTAL_P = TOTAL_N / 2;
    localparam int CNT_W   = $clog2(TOTAL_N + 1);
    localparam int PE_W    = $clog2(NPE + 1);
    localparam int WV_W    = $clog2(RF_WIDTH / DATA_WIDTH + 1);

    wr_state_t             state;
    wr_mode_t              mode;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      left_q;
    logic [8:0]            len_q;
    logic [8:0]            burst_beat;
    logic [PE_W-1:0]       pe_idx;
    logic [WV_W-1:0]       wave_idx;

    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] plan_addr;
    logic [ADDR_WIDTH-1:0] plan_next;
    logic [CNT_W-1:0]      plan_left;
    logic [8:0]            plan_len;
    logic                  launch;

    logic [RF_WIDTH-1:0]   rf;
    logic [RF_WIDTH/2-1:0] packed_s;
    logic [RF_WIDTH-1:0]   stream;

    assign aligned   = base_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign plan_addr = (state == S_IDLE) ? aligned : addr_q;
    assign plan_left = (state != S_IDLE) ? left_q :
                       pack_fp16 ? CNT_W'(TOTAL_P) : CNT_W'(TOTAL_N);

    wr_burst_planner #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .CNT_W     (CNT_W),
        .SIZE      (SIZE),
        .MAX_BURST (MAX_BURST)
    ) u_planner (
        .addr      (plan_addr),
        .beats_left(plan_left),
        .len       (plan_len),
        .next_addr (plan_next)
    );

    // A burst is issued from IDLE on start, or from RESP while beats remain.
    assign launch = (state == S_IDLE && start && !done) ||
                    (state == S_RESP && axi_bvalid && left_q != '0);

    always_comb begin
        rf       = regfiles[int'(pe_idx)*RF_WIDTH +: RF_WIDTH];
        packed_s = '0;
        for (int k = 0; k < RF_WIDTH / 32; k++)
            packed_s[16*k +: 16] = rf[32*k +: 16];
        stream    = (mode == WR_PACK_FP16) ?
                    {{(RF_WIDTH/2){1'b0}}, packed_s} : rf;
        axi_wdata = stream[int'(wave_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign axi_wlast   = (state == S_DATA) && (burst_beat == len_q - 9'd1);
    assign axi_awsize  = 3'(SIZE);
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_wstrb   = '1;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mode        <= WR_NORMAL;
            addr_q      <= '0;
            left_q      <= '0;
            len_q       <= '0;
            burst_beat  <= '0;
            pe_idx      <= '0;
            wave_idx    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (launch) begin
                        mode       <= pack_fp16 ? WR_PACK_FP16 : WR_NORMAL;
                        err        <= 1'b0;
                        burst_beat <= '0;
                        pe_idx     <= '0;
                        wave_idx   <= '0;
                    end
                end
                S_ADDR: begin
                    if (axi_awready) begin
                        axi_awvalid <= 1'b0;
                        axi_wvalid  <= 1'b1;
                        state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (axi_wready) begin
                        if (pe_idx == PE_W'(NPE - 1)) begin
                            pe_idx   <= '0;
                            wave_idx <= wave_idx + WV_W'(1);
                        end else begin
                            pe_idx <= pe_idx + PE_W'(1);
                        end
                        if (axi_wlast) begin
                            burst_beat <= '0;
                            axi_wvalid <= 1'b0;
                            axi_bready <= 1'b1;
                            state      <= S_RESP;
                        end else begin
                            burst_beat <= burst_beat + 9'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        err        <= err | (axi_bresp != AXI_RESP_OKAY);
                        if (left_q == '0) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (launch) begin
                axi_awvalid <= 1'b1;
                axi_awaddr  <= plan_addr;
                axi_awlen   <= 8'(plan_len - 9'd1);
                len_q       <= plan_len;
                addr_q      <= plan_next;
                left_q      <= plan_left - CNT_W'(plan_len);
                state       <= S_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_axi_tensor_wr_burst.sv
// Scoreboard bench: expected AW/W/done pushed at issue, popped by monitors.
module tb_axi_tensor_wr_burst;

    localparam int R   = 8;
    localparam int C   = 8;
    localparam int RF  = 128;
    localparam int NPE = R * C;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [R*C*RF-1:0] regfiles;

    logic        start0, pack0, busy0, done0, err0;
    logic [31:0] base0, awaddr0, wdata0;
    logic        awvalid0, awready0, wvalid0, wready0, wlast0;
    logic        bvalid0, bready0;
    logic [7:0]  awlen0;
    logic [2:0]  awsize0;
    logic [1:0]  awburst0, bresp0;
    logic [3:0]  wstrb0;

    logic        start1, pack1, busy1, done1, err1;
    logic [31:0] base1, awaddr1;
    logic [63:0] wdata1;
    logic        awvalid1, awready1, wvalid1, wready1, wlast1;
    logic        bvalid1, bready1;
    logic [7:0]  awlen1;
    logic [2:0]  awsize1;
    logic [1:0]  awburst1, bresp1;
    logic [7:0]  wstrb1;

    axi_tensor_wr_burst u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .pack_fp16(pack0),
        .base_addr(base0), .regfiles(regfiles),
        .busy(busy0), .done(done0), .err(err0),
        .axi_awvalid(awvalid0), .axi_awready(awready0),
        .axi_awaddr(awaddr0), .axi_awlen(awlen0),
        .axi_awsize(awsize0), .axi_awburst(awburst0),
        .axi_wvalid(wvalid0), .axi_wready(wready0),
        .axi_wdata(wdata0), .axi_wstrb(wstrb0), .axi_wlast(wlast0),
        .axi_bvalid(bvalid0), .axi_bready(bready0), .axi_bresp(bresp0)
    );

    axi_tensor_wr_burst #(.DATA_WIDTH(64), .MAX_BURST(16)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .pack_fp16(pack1),
        .base_addr(base1), .regfiles(regfiles),
        .busy(busy1), .done(done1), .err(err1),
        .axi_awvalid(awvalid1), .axi_awready(awready1),
        .axi_awaddr(awaddr1), .axi_awlen(awlen1),
        .axi_awsize(awsize1), .axi_awburst(awburst1),
        .axi_wvalid(wvalid1), .axi_wready(wready1),
        .axi_wdata(wdata1), .axi_wstrb(wstrb1), .axi_wlast(wlast1),
        .axi_bvalid(bvalid1), .axi_bready(bready1), .axi_bresp(bresp1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    aw_t         expaw0[$], expaw1[$];
    logic [63:0] expw0[$], expw1[$];
    logic        expdone0[$], expdone1[$];
    logic [1:0]  respq0[$];
    logic [31:0] cap0[$];
    int bpend0 = 0, bpend1 = 0, brem0 = 0, brem1 = 0;
    int aw_cnt0 = 0;
    bit stall0 = 0;
    bit hold1 = 0;
    logic [63:0] hold_data1;
    logic hold_last1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic failmsg(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    function automatic logic [63:0] exp_beat(int n, int dw, bit pk);
        logic [127:0] w, s;
        int pe, wv;
        pe = n % NPE;
        wv = n / NPE;
        w  = regfiles[pe*RF +: RF];
        if (pk) begin
            s = '0;
            for (int k = 0; k < RF / 32; k++) s[16*k +: 16] = w[32*k +: 16];
        end else begin
            s = w;
        end
        s = s >> (wv * dw);
        return (dw == 32) ? {32'b0, s[31:0]} : s[63:0];
    endfunction

    task automatic exp_xfer0(input bit pk, input bit e);
        int total;
        total = pk ? 128 : 256;
        for (int n = 0; n < total; n++) expw0.push_back(exp_beat(n, 32, pk));
        expdone0.push_back(e);
        cap0 = {};
    endtask

    task automatic go0(input bit pk, input logic [31:0] b);
        @(negedge clk);
        start0 = 1'b1;
        pack0  = pk;
        base0  = b;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input int budget);
        int i;
        i = 0;
        while (!done0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!done0) failmsg("done0_timeout");
    endtask

    task automatic drained0(input string nm);
        repeat (2) @(negedge clk);
        chk({nm, "_aw_left"}, 64'(expaw0.size()), 0);
        chk({nm, "_w_left"}, 64'(expw0.size()), 0);
        chk({nm, "_done_left"}, 64'(expdone0.size()), 0);
    endtask

    // Monitor / responder for the default-parameter instance.
    initial forever begin
        aw_t e;
        @(negedge clk);
        awready0 = stall0 ? 1'($urandom_range(0, 1)) : 1'b1;
        wready0  = stall0 ? 1'($urandom_range(0, 1)) : 1'b1;
        bvalid0  = (bpend0 > 0);
        bresp0   = (bpend0 > 0 && respq0.size() > 0) ? respq0[0] : 2'b00;
        if (!rst) begin
            chk("one_channel0", 64'($countones({awvalid0, wvalid0, bready0}) > 1), 0);
            if (awvalid0 && awready0) begin
                if (expaw0.size() == 0) failmsg("aw0_unexpected");
                else begin
                    e = expaw0.pop_front();
                    chk("awaddr0", 64'(awaddr0), 64'(e.addr));
                    chk("awlen0", 64'(awlen0), 64'(e.len));
                    chk("awsize0", 64'(awsize0), 2);
                    chk("awburst0", 64'(awburst0), 1);
                    brem0 = int'(e.len) + 1;
                end
                aw_cnt0++;
            end
            if (wvalid0 && wready0) begin
                if (expw0.size() == 0) failmsg("w0_unexpected");
                else chk("wdata0", 64'(wdata0), expw0.pop_front());
                chk("wlast0", 64'(wlast0), 64'(brem0 == 1));
                chk("wstrb0", 64'(wstrb0), 64'hF);
                brem0--;
                cap0.push_back(wdata0);
                if (wlast0) bpend0++;
            end
            if (bvalid0 && bready0) begin
                bpend0--;
                if (respq0.size() > 0) void'(respq0.pop_front());
            end
            if (done0) begin
                if (expdone0.size() == 0) failmsg("done0_unexpected");
                else chk("err0", 64'(err0), 64'(expdone0.pop_front()));
            end
        end
    end

    // Monitor / responder for the 64-bit, 16-beat instance with stalls.
    initial forever begin
        aw_t e;
        @(negedge clk);
        awready1 = 1'($urandom_range(0, 1));
        wready1  = 1'($urandom_range(0, 1));
        bvalid1  = (bpend1 > 0);
        bresp1   = 2'b00;
        if (!rst) begin
            if (hold1 && wvalid1) begin
                chk("wdata1_stable", wdata1, hold_data1);
                chk("wlast1_stable", 64'(wlast1), 64'(hold_last1));
            end
            hold1      = wvalid1 && !wready1;
            hold_data1 = wdata1;
            hold_last1 = wlast1;
            if (awvalid1 && awready1) begin
                if (expaw1.size() == 0) failmsg("aw1_unexpected");
                else begin
                    e = expaw1.pop_front();
                    chk("awaddr1", 64'(awaddr1), 64'(e.addr));
                    chk("awlen1", 64'(awlen1), 64'(e.len));
                    chk("awsize1", 64'(awsize1), 3);
                    brem1 = int'(e.len) + 1;
                end
            end
            if (wvalid1 && wready1) begin
                if (expw1.size() == 0) failmsg("w1_unexpected");
                else chk("wdata1", wdata1, expw1.pop_front());
                chk("wlast1", 64'(wlast1), 64'(brem1 == 1));
                chk("wstrb1", 64'(wstrb1), 64'hFF);
                brem1--;
                if (wlast1) bpend1++;
            end
            if (bvalid1 && bready1) bpend1--;
            if (done1) begin
                if (expdone1.size() == 0) failmsg("done1_unexpected");
                else chk("err1", 64'(err1), 64'(expdone1.pop_front()));
            end
        end
    end

    initial begin
        logic [127:0] rf00;
        int i, aw_before;
        rst = 1'b1;
        start0 = 0; pack0 = 0; base0 = 0;
        start1 = 0; pack1 = 0; base1 = 0;
        for (int k = 0; k < NPE * RF / 32; k++)
            regfiles[k*32 +: 32] = {8'(k), 8'(k ^ 8'h5A), 16'(k * 257 + 16'h1234)};
        rf00 = regfiles[127:0];

        #2;
        chk("rst_busy", 64'(busy0), 0);
        chk("rst_done", 64'(done0), 0);
        chk("rst_err", 64'(err0), 0);
        chk("rst_awvalid", 64'(awvalid0), 0);
        chk("rst_wvalid", 64'(wvalid0), 0);
        chk("rst_bready", 64'(bready0), 0);
        chk("rst_wlast", 64'(wlast0), 0);
        chk("rst_awaddr", 64'(awaddr0), 0);
        chk("rst_awlen", 64'(awlen0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // single 256-beat burst, then a start coinciding with done
        expaw0.push_back('{32'h0, 8'd255});
        exp_xfer0(0, 0);
        go0(0, 32'h0);
        chk("busy_after_start", 64'(busy0), 1);
        wait_done0(2000);
        start0 = 1'b1;
        base0  = 32'h4000;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("start_on_done_ignored", 64'(busy0), 0);
        drained0("normal0");

        // packed mode
        expaw0.push_back('{32'h0, 8'd127});
        exp_xfer0(1, 0);
        go0(1, 32'h0);
        wait_done0(2000);
        drained0("packed0");
        chk("packed_beat0", 64'(cap0[0]), 64'({rf00[47:32], rf00[15:0]}));
        chk("packed_beat64", 64'(cap0[64]), 64'({rf00[111:96], rf00[79:64]}));

        // 4 KB split with unaligned base low bits
        expaw0.push_back('{32'hF00, 8'd63});
        expaw0.push_back('{32'h1000, 8'd191});
        exp_xfer0(0, 0);
        go0(0, 32'h0000_0F03);
        wait_done0(2000);
        drained0("split0");

        // exactly reaching the page end stays one burst
        stall0 = 1;
        expaw0.push_back('{32'hC00, 8'd255});
        exp_xfer0(0, 0);
        go0(0, 32'h0000_0C00);
        wait_done0(4000);
        drained0("pageend0");

        // packed split
        expaw0.push_back('{32'hFC0, 8'd15});
        expaw0.push_back('{32'h1000, 8'd111});
        exp_xfer0(1, 0);
        go0(1, 32'h0000_0FC0);
        wait_done0(4000);
        drained0("packsplit0");
        stall0 = 0;

        // SLVERR on first burst, transfer continues, then clean
        respq0.push_back(2'b10);
        respq0.push_back(2'b00);
        expaw0.push_back('{32'hF00, 8'd63});
        expaw0.push_back('{32'h1000, 8'd191});
        exp_xfer0(0, 1);
        go0(0, 32'h0000_0F00);
        wait_done0(2000);
        drained0("slverr0");
        expaw0.push_back('{32'h2000, 8'd255});
        exp_xfer0(0, 0);
        go0(0, 32'h0000_2000);
        wait_done0(2000);
        drained0("clean0");

        // start while busy, then reset mid-DATA
        aw_before = aw_cnt0;
        expaw0.push_back('{32'h0, 8'd255});
        exp_xfer0(0, 0);
        go0(0, 32'h0);
        i = 0;
        while (cap0.size() < 5 && i < 500) begin @(negedge clk); i++; end
        start0 = 1'b1;
        base0  = 32'h3000;
        @(negedge clk);
        start0 = 1'b0;
        while (cap0.size() < 20 && i < 500) begin @(negedge clk); i++; end
        chk("busy_start_ignored", 64'(aw_cnt0 - aw_before), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_awvalid", 64'(awvalid0), 0);
        chk("abort_wvalid", 64'(wvalid0), 0);
        chk("abort_busy", 64'(busy0), 0);
        chk("abort_bready", 64'(bready0), 0);
        expaw0 = {}; expw0 = {}; expdone0 = {}; respq0 = {};
        bpend0 = 0; brem0 = 0;
        @(negedge clk);
        rst = 1'b0;
        expaw0.push_back('{32'h0, 8'd255});
        exp_xfer0(0, 0);
        go0(0, 32'h0);
        wait_done0(2000);
        drained0("after_rst0");

        // 64-bit beats, 16-beat bursts, random stalls
        for (int k = 0; k < 8; k++) expaw1.push_back('{32'(k * 128), 8'd15});
        for (int n = 0; n < 128; n++) expw1.push_back(exp_beat(n, 64, 0));
        expdone1.push_back(1'b0);
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        i = 0;
        while (!done1 && i < 5000) begin @(negedge clk); i++; end
        if (!done1) failmsg("done1_timeout");
        repeat (2) @(negedge clk);
        chk("aw1_left", 64'(expaw1.size()), 0);
        chk("w1_left", 64'(expw1.size()), 0);
        chk("done1_left", 64'(expdone1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
